// File: rtl/vga_update_ctrl.sv
// Blanking-window scheduler: opens an update window at each vsync fall and round-robins req/gnt/done between score (bit 0) and timer (bit 1); VGA_UPD_TIMEOUT_EN builds the hold timeout and the last-line no-grant rule.
// All outputs registered, one cycle after the sampled input; a grant is held until done, timeout or window close.
module vga_update_ctrl #(
    parameter int BLANK_LINES = 30,
    parameter int MAX_HOLD    = 64,
    parameter int FRAME_W     = 8
) (
    input  logic               clk_vga,
    input  logic               rst_vga,
    input  logic               h_out_vga,
    input  logic               v_out_vga,
    input  logic [1:0]         req,
    input  logic [1:0]         done,
    output logic [1:0]         gnt,
    output logic               upd_window,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               frame_tick,
    output logic               timeout_err
);
    localparam logic [1:0] WAIT_VS = 2'd0;
    localparam logic [1:0] WINDOW  = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam int LW = $clog2(BLANK_LINES + 1);

    if (BLANK_LINES < 1 || BLANK_LINES > 35 || MAX_HOLD < 1 || MAX_HOLD > 799) begin : g_param_check
        $error("vga_update_ctrl: BLANK_LINES or MAX_HOLD out of range");
    end

    logic [1:0]    state;
    logic          v_prev;
    logic          h_prev;
    logic [LW-1:0] line_cnt;
    logic          ptr;
    logic          v_fall;
    logic          h_fall;
    logic          closing;
    logic          grant_ok;
    logic [1:0]    pick;

    assign v_fall  = v_prev & ~v_out_vga;
    assign h_fall  = h_prev & ~h_out_vga;
    assign closing = h_fall && ((line_cnt + LW'(1)) == LW'(BLANK_LINES));

`ifdef VGA_UPD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;

    // The last line is off limits so a grant always finishes before the window closes.
    assign grant_ok = (line_cnt != LW'(BLANK_LINES - 1));
`else
    assign grant_ok    = 1'b1;
    assign timeout_err = 1'b0;
`endif

    // ptr=0 favours score (bit 0), ptr=1 favours timer (bit 1).
    always_comb begin
        pick = 2'b00;
        if (ptr) begin
            if (req[1])      pick = 2'b10;
            else if (req[0]) pick = 2'b01;
        end else begin
            if (req[0])      pick = 2'b01;
            else if (req[1]) pick = 2'b10;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst_vga) begin
            state      <= WAIT_VS;
            v_prev     <= 1'b0;
            h_prev     <= 1'b0;
            line_cnt   <= '0;
            ptr        <= 1'b0;
            gnt        <= 2'b00;
            upd_window <= 1'b0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
`ifdef VGA_UPD_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            v_prev     <= v_out_vga;
            h_prev     <= h_out_vga;
            frame_tick <= 1'b0;
            if (v_fall) begin
                frame_cnt  <= frame_cnt + FRAME_W'(1);
                frame_tick <= 1'b1;
                line_cnt   <= '0;
                upd_window <= 1'b1;
                state      <= WINDOW;
                if (gnt != 2'b00) begin
                    gnt <= 2'b00;
                    ptr <= gnt[0];
                end
            end else if (state != WAIT_VS) begin
                if (h_fall) line_cnt <= line_cnt + LW'(1);
                if (closing) begin
                    upd_window <= 1'b0;
                    state      <= WAIT_VS;
                    if (gnt != 2'b00) begin
                        gnt <= 2'b00;
                        ptr <= gnt[0];
                    end
                end else if (state == WINDOW) begin
                    if (grant_ok && pick != 2'b00) begin
                        gnt   <= pick;
                        state <= GRANT;
`ifdef VGA_UPD_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end else if ((done & gnt) != 2'b00) begin
                    gnt   <= 2'b00;
                    ptr   <= gnt[0];
                    state <= WINDOW;
                end
`ifdef VGA_UPD_TIMEOUT_EN
                else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    gnt         <= 2'b00;
                    ptr         <= gnt[0];
                    state       <= WINDOW;
                    timeout_err <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_vga_update_ctrl.sv
// Bench for vga_update_ctrl: compressed sync timing (8 lines of 100 cycles), reference model of the window/arbitration rules.
module tb_vga_update_ctrl;
    localparam int LINE  = 100;
    localparam int FL    = 8;
    localparam int FRAME = LINE * FL;
    localparam int BL    = 4;
    localparam int MH    = 64;
    localparam int FW    = 3;

    logic          clk_vga   = 1'b0;
    logic          rst_vga   = 1'b1;
    logic          h_out_vga = 1'b1;
    logic          v_out_vga = 1'b1;
    logic [1:0]    req       = 2'b00;
    logic [1:0]    done      = 2'b00;
    logic [1:0]    gnt;
    logic          upd_window;
    logic [FW-1:0] frame_cnt;
    logic          frame_tick;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int gpos = FRAME - 5;
    int rhc = 0;
    int resp_mode = 0;
    bit gen_en = 1'b0;

    vga_update_ctrl #(.BLANK_LINES(BL), .MAX_HOLD(MH), .FRAME_W(FW)) dut (
        .clk_vga(clk_vga), .rst_vga(rst_vga), .h_out_vga(h_out_vga), .v_out_vga(v_out_vga),
        .req(req), .done(done), .gnt(gnt), .upd_window(upd_window), .frame_cnt(frame_cnt),
        .frame_tick(frame_tick), .timeout_err(timeout_err)
    );

    always #20 clk_vga = ~clk_vga;

    // Sync generator: hsync low for 10 cycles at each line start, vsync low for lines 0..1.
    always @(negedge clk_vga) begin
        if (gen_en) begin
            gpos = (gpos + 1) % FRAME;
            h_out_vga = (gpos % LINE) >= 10;
            v_out_vga = gpos >= 2 * LINE;
        end else begin
            h_out_vga = 1'b1;
            v_out_vga = 1'b1;
        end
    end

    // Requester side: mode 1 = done after 5 granted cycles, mode 2 = random done.
    always @(negedge clk_vga) begin
        if (resp_mode == 1) begin
            if (gnt != 2'b00) begin
                rhc = rhc + 1;
                done = (rhc == 5) ? gnt : 2'b00;
            end else begin
                rhc = 0;
                done = 2'b00;
            end
        end else if (resp_mode == 2) begin
            done = 2'($urandom_range(0, 3));
        end else begin
            rhc = 0;
            done = 2'b00;
        end
    end

    // Reference model: who holds the bus, window open/closed, lines seen, cycles held.
    int m_holder = -1, m_pref = 0, m_held = 0, m_line = 0, m_frames = 0;
    bit m_open = 0, m_tick = 0, m_err = 0, m_vp = 0, m_hp = 0;

    always @(posedge clk_vga) begin : model
        int hol, pref, held, line, frames, old_line;
        bit open, err, tick, vf, hf, closing, may_grant;
        hol = m_holder; pref = m_pref; held = m_held; line = m_line; frames = m_frames;
        open = m_open; err = m_err; tick = 1'b0; closing = 1'b0;
        if (rst_vga) begin
            hol = -1; pref = 0; held = 0; line = 0; frames = 0; open = 0; err = 0;
        end else begin
            vf = m_vp && !v_out_vga;
            hf = m_hp && !h_out_vga;
            if (vf) begin
                frames = (frames + 1) % (1 << FW);
                tick = 1'b1; line = 0; open = 1'b1;
                if (hol >= 0) begin pref = 1 - hol; hol = -1; end
            end else if (open) begin
                old_line = line;
                if (hf) begin line = line + 1; closing = (line == BL); end
                if (closing) begin
                    open = 1'b0;
                    if (hol >= 0) begin pref = 1 - hol; hol = -1; end
                end else if (hol < 0) begin
`ifdef VGA_UPD_TIMEOUT_EN
                    may_grant = (old_line != BL - 1);
`else
                    may_grant = 1'b1;
`endif
                    if (req != 2'b00 && may_grant) begin
                        hol = req[pref] ? pref : 1 - pref;
                        held = 0;
                    end
                end else if (done[hol]) begin
                    pref = 1 - hol; hol = -1;
                end else begin
`ifdef VGA_UPD_TIMEOUT_EN
                    held = held + 1;
                    if (held == MH) begin err = 1'b1; pref = 1 - hol; hol = -1; end
`endif
                end
            end
        end
        m_holder <= hol; m_pref <= pref; m_held <= held; m_line <= line; m_frames <= frames;
        m_open <= open; m_err <= err; m_tick <= tick;
        m_vp <= rst_vga ? 1'b0 : v_out_vga;
        m_hp <= rst_vga ? 1'b0 : h_out_vga;
    end

    logic [FW+4:0] dut_v, mdl_v;
    assign dut_v = {gnt, upd_window, frame_cnt, frame_tick, timeout_err};
    assign mdl_v = {(m_holder == 0) ? 2'b01 : (m_holder == 1) ? 2'b10 : 2'b00,
                    m_open, m_frames[FW-1:0], m_tick, m_err};

    task automatic step();
        @(negedge clk_vga);
        #1;
    endtask

    task automatic do_reset();
        rst_vga = 1'b1;
        step();
        step();
        rst_vga = 1'b0;
    endtask

    task automatic wait_gpos(input int target);
        for (int i = 0; i < 2 * FRAME && gpos != target; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        checks++;
        if (gpos != target) begin errors++; $display("FAIL wait_gpos got=%0d want=%0d", gpos, target); end
    endtask

    task automatic test_reset();
        gen_en = 1'b0; req = 2'b00; resp_mode = 0;
        rst_vga = 1'b1;
        repeat (3) step();
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL reset_outputs got=%b want=0", dut_v); end
        rst_vga = 1'b0;
        req = 2'b11;
        repeat (20) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL no_window_before_vsync got=%b want=0", dut_v); end
        req = 2'b00;
    endtask

    task automatic test_frames();
        bit found = 0, wrapped = 0;
        int n = 0, win = 0;
        logic [FW-1:0] last;
        gen_en = 1'b1;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (frame_tick) found = 1;
        end
        checks++;
        if (!found || gpos != 1) begin errors++; $display("FAIL first_tick found=%0d gpos=%0d want gpos=1", found, gpos); end
        checks++;
        if (frame_cnt !== FW'(1)) begin errors++; $display("FAIL first_frame_cnt got=%0d want=1", frame_cnt); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            n++;
            if (upd_window) win++;
            if (frame_tick) break;
        end
        checks++;
        if (n != FRAME) begin errors++; $display("FAIL tick_period got=%0d want=%0d", n, FRAME); end
        checks++;
        if (win != BL * LINE) begin errors++; $display("FAIL window_len got=%0d want=%0d", win, BL * LINE); end
        last = frame_cnt;
        for (int i = 0; i < 8 * FRAME && !wrapped; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (frame_tick) begin
                checks++;
                if (frame_cnt !== FW'(last + 1)) begin errors++; $display("FAIL frame_inc got=%0d want=%0d", frame_cnt, FW'(last + 1)); end
                if (frame_cnt == '0) wrapped = 1;
                last = frame_cnt;
            end
        end
        checks++;
        if (!wrapped) begin errors++; $display("FAIL frame_wrap got=no_wrap want=wrap_to_0"); end
    endtask

    task automatic test_round_robin();
        logic [1:0] gv[6];
        int gl[6], gap[6];
        int ng = 0, hi = 0, low = 0;
        logic [1:0] pg = 2'b00;
        do_reset();
        wait_gpos(FRAME - 50);
        req = 2'b11; resp_mode = 1;
        for (int i = 0; i < 2 * FRAME && ng < 6; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (gnt != 2'b00 && pg == 2'b00) begin gv[ng] = gnt; gap[ng] = low; hi = 0; end
            if (gnt != 2'b00) hi++;
            if (gnt == 2'b00 && pg != 2'b00) begin gl[ng] = hi; ng++; low = 1; end
            else if (gnt == 2'b00) low++;
            pg = gnt;
        end
        checks++;
        if (ng != 6) begin errors++; $display("FAIL rr_grant_count got=%0d want=6", ng); end
        for (int k = 0; k < ng; k++) begin
            checks++;
            if (gv[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || gl[k] != 5 || (k > 0 && gap[k] != 1)) begin
                errors++;
                $display("FAIL rr_grant%0d gnt=%b len=%0d gap=%0d want gnt=%b len=5 gap=1", k, gv[k], gl[k], gap[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        resp_mode = 0; req = 2'b00;
    endtask

    task automatic test_early_req();
        bit rose = 0;
        logic pw;
        do_reset();
        wait_gpos(BL * LINE + 50);
        req = 2'b01;
        pw = upd_window;
        for (int i = 0; i < 2 * FRAME && !rose; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (upd_window && !pw) rose = 1;
            pw = upd_window;
        end
        checks++;
        if (!rose || gnt !== 2'b00) begin errors++; $display("FAIL early_req_open rose=%0d gnt=%b want gnt=00", rose, gnt); end
        step();
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL early_req_grant got=%b want=01", gnt); end
        req = 2'b00;
    endtask

    task automatic test_timeout();
        int hi = 0;
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 2 * FRAME && gnt == 2'b00; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        for (int i = 0; i < 1000 && gnt != 2'b00; i++) begin
            hi++;
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
`ifdef VGA_UPD_TIMEOUT_EN
        checks++;
        if (hi != MH) begin errors++; $display("FAIL timeout_hold got=%0d want=%0d", hi, MH); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b want=1", timeout_err); end
        repeat (300) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b want=0", timeout_err); end
`else
        checks++;
        if (hi <= MH || upd_window !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_to_close len=%0d win=%b err=%b want len>%0d win=0 err=0", hi, upd_window, timeout_err, MH);
        end
`endif
        req = 2'b00;
    endtask

    task automatic test_last_line();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 2 * FRAME && !frame_tick; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        wait_gpos((BL - 1) * LINE + 1);
        req = 2'b01;
`ifdef VGA_UPD_TIMEOUT_EN
        for (int i = 0; i < 2 * LINE && upd_window; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (gnt != 2'b00) bad++;
        end
        for (int i = 0; i < 2 * FRAME && !upd_window; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (gnt != 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || !upd_window) begin errors++; $display("FAIL last_line_no_grant granted_cycles=%0d win=%b want 0 and 1", bad, upd_window); end
        step();
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL last_line_next_window got=%b want=01", gnt); end
`else
        step();
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL last_line_grant got=%b want=01", gnt); end
        for (int i = 0; i < 2 * LINE && gnt != 2'b00; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        checks++;
        if (gnt !== 2'b00 || upd_window !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL last_line_drop gnt=%b win=%b err=%b want 00 0 0", gnt, upd_window, timeout_err);
        end
`endif
        req = 2'b00;
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 2 * FRAME && gnt == 2'b00; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
        end
        repeat (3) step();
        rst_vga = 1'b1;
        step();
        rst_vga = 1'b0;
        checks++;
        if (dut_v !== '0) begin errors++; $display("FAIL mid_reset_outputs got=%b want=0", dut_v); end
        for (int i = 0; i < 2 * FRAME && !frame_tick; i++) begin
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (gnt != 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || !frame_tick || frame_cnt !== FW'(1)) begin
            errors++;
            $display("FAIL mid_reset_no_grant granted=%0d tick=%b fc=%0d want 0 1 1", bad, frame_tick, frame_cnt);
        end
        step();
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL mid_reset_first_grant got=%b want=01", gnt); end
        req = 2'b00;
    endtask

    task automatic test_random();
        int grants = 0;
        logic [1:0] pg = 2'b00;
        do_reset();
        resp_mode = 2;
        for (int i = 0; i < 4 * FRAME; i++) begin
            req = 2'($urandom_range(0, 3));
            step();
            checks++; if (dut_v !== mdl_v) begin errors++; $display("FAIL model_cmp t=%0t dut=%b exp=%b", $time, dut_v, mdl_v); end
            if (gnt != 2'b00 && pg == 2'b00) grants++;
            pg = gnt;
        end
        checks++;
        if (grants == 0) begin errors++; $display("FAIL random_activity grants=%0d want>0", grants); end
        resp_mode = 0; req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_round_robin();
        test_early_req();
        test_timeout();
        test_last_line();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
